// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: shadow/active digit registers with
// frame-synchronous commit, ON/GAP scan FSM and registered segment/common drives.
module seg_scan_ctrl #(
  parameter int NUM_DIG = 8,
  parameter int ON_CYC  = 9000,
  parameter int GAP_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       wr_blank,
  input  logic       commit,
  output logic       commit_ack,
  output logic [7:0] seg_d,
  output logic [7:0] seg_com,
  output logic       frame_done
);

  localparam int MAX_CYC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [2:0] IDX_LAST = 3'(NUM_DIG - 1);
  // Digit entry layout is {blank, dp, hex}; reset leaves every digit dark.
  localparam logic [5:0] ENTRY_RST = 6'b10_0000;

  typedef enum logic {ST_ON = 1'b0, ST_GAP = 1'b1} scan_state_t;

  scan_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic             pending_r;
  logic [5:0]       shadow_r [NUM_DIG];
  logic [5:0]       active_r [NUM_DIG];

  logic       on_done_s;
  logic       gap_done_s;
  logic       boundary_s;
  logic       copy_s;
  logic [5:0] cur_entry_s;
  logic [7:0] on_pattern_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3f;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5b;
      4'h3: seg = 7'h4f;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6d;
      4'h6: seg = 7'h7d;
      4'h7: seg = 7'h27;
      4'h8: seg = 7'h7f;
      4'h9: seg = 7'h6f;
      4'hA: seg = 7'h5f;
      4'hB: seg = 7'h7c;
      4'hC: seg = 7'h58;
      4'hD: seg = 7'h5e;
      4'hE: seg = 7'h7b;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Window-end detection, frame boundary and the pattern for the lit digit.
  always_comb begin
    on_done_s   = (cnt_r == ON_LAST);
    gap_done_s  = (cnt_r == GAP_LAST);
    boundary_s  = (state_r == ST_GAP) && gap_done_s && (idx_r == IDX_LAST);
    copy_s      = boundary_s && (pending_r || commit);
    cur_entry_s = active_r[idx_r];
    if (cur_entry_s[5]) begin
      on_pattern_s = 8'h00;
    end else begin
      on_pattern_s = {cur_entry_s[4], hex_to_seg(cur_entry_s[3:0])};
    end
  end

  // Shadow register file, written directly by the host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIG; i++) shadow_r[i] <= ENTRY_RST;
    end else if (wr_en) begin
      shadow_r[wr_addr] <= {wr_blank, wr_dp, wr_data};
    end
  end

  // Scan FSM, commit handshake, active copy and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_ON;
      cnt_r      <= '0;
      idx_r      <= 3'd0;
      pending_r  <= 1'b0;
      commit_ack <= 1'b0;
      frame_done <= 1'b0;
      seg_com    <= 8'hFF;
      seg_d      <= 8'h00;
      for (int i = 0; i < NUM_DIG; i++) active_r[i] <= ENTRY_RST;
    end else begin
      commit_ack <= copy_s;
      frame_done <= boundary_s;
      // Non-blocking copy picks up the shadow as it was before any same-edge write.
      if (copy_s) begin
        for (int i = 0; i < NUM_DIG; i++) active_r[i] <= shadow_r[i];
        pending_r <= 1'b0;
      end else if (commit) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        ST_ON: begin
          seg_com <= ~(8'h01 << idx_r);
          seg_d   <= on_pattern_s;
          if (on_done_s) begin
            state_r <= ST_GAP;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_GAP: begin
          seg_com <= 8'hFF;
          seg_d   <= 8'h00;
          if (gap_done_s) begin
            state_r <= ST_ON;
            cnt_r   <= '0;
            idx_r   <= (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= ST_ON;
          cnt_r   <= '0;
          idx_r   <= 3'd0;
          seg_com <= 8'hFF;
          seg_d   <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIG, default 8, number of multiplexed digits (fixed at 8 in this revision).
REQ-002 Parameter ON_CYC, default 9000, clock cycles a digit is lit.
REQ-003 Parameter GAP_CYC, default 1000, all-off anti-ghost cycles after each digit (GAP_CYC >= 1).
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wr_en  input  1  write strobe to the shadow digit register.
REQ-007 wr_addr  input  3  digit index written.
REQ-008 wr_data  input  4  hex value 0..F.
REQ-009 wr_dp  input  1  decimal point for the written digit.
REQ-010 wr_blank  input  1  1 = digit dark.
REQ-011 commit  input  1  request transfer of shadow to active at next frame boundary.
REQ-012 commit_ack  output  1  one-cycle pulse when the transfer happens.
REQ-013 seg_d  output  8  segment pattern, bit7 = dp, bits6:0 = a..g, active-high.
REQ-014 seg_com  output  8  digit select, active-low, bit i = digit i.
REQ-015 frame_done  output  1  one-cycle pulse at end of each full scan frame.

Function
REQ-016 Shadow register holds {blank, dp, hex} per digit; wr_en=1 writes entry wr_addr at the clock edge.
REQ-017 Active register drives the display; it changes only by whole-frame copy from shadow, never by direct write.
REQ-018 Scan FSM has two states: ON and GAP; counter cnt and digit index idx (0..NUM_DIG-1).
REQ-019 ON: seg_com = ~(1<<idx) for exactly ON_CYC cycles, then GAP.
REQ-020 GAP: seg_com = 8'hFF, seg_d = 8'h00 for exactly GAP_CYC cycles, then ON with idx+1, wrapping NUM_DIG-1 -> 0.
REQ-021 In ON, seg_d[6:0] = hex decode: 0:3f 1:06 2:5b 3:4f 4:66 5:6d 6:7d 7:27 8:7f 9:6f A:5f B:7c C:58 D:5e E:7b F:71; seg_d[7] = dp.
REQ-022 In ON with blank=1 for idx, seg_d = 8'h00 (dp also off) while seg_com still selects the digit.
REQ-023 seg_d and seg_com are registered outputs; no combinational path from any input to them.
REQ-024 Frame boundary = last GAP cycle of idx NUM_DIG-1; frame_done pulses high for that one cycle.
REQ-025 commit sets a pending flag; extra commits while pending are merged (single transfer).
REQ-026 At a frame boundary with pending=1 or commit=1, active <= shadow, pending cleared, commit_ack pulses that same cycle.
REQ-027 wr_en in the copy cycle: copy takes pre-edge shadow contents; the new write remains in shadow for the next commit.
REQ-028 Writes without commit never reach the display.
REQ-029 Frame length is exactly NUM_DIG*(ON_CYC+GAP_CYC) cycles; frame_done period equals it.

Reset
REQ-030 rst_n=0 asynchronously forces: state ON, idx 0, cnt 0, pending 0, all shadow and active entries {blank=1, dp=0, hex=0}.
REQ-031 During reset: seg_com = 8'hFF, seg_d = 8'h00, commit_ack = 0, frame_done = 0.
REQ-032 First rising edge after rst_n release starts digit 0 ON window (seg_com = 8'hFE, seg_d = 8'h00 since blanked).
REQ-033 Reset mid-frame discards pending commit and restarts scan at digit 0.

Verification (ON_CYC=4, GAP_CYC=2)
REQ-034 Reset release, no writes -> seg_com cycles FE x4, FF x2, FD x4, ... 7F x4, FF x2; seg_d always 00; frame_done every 48 cycles.
REQ-035 Write digit0=hex 3, dp=1, blank=0, then commit -> at next boundary commit_ack=1; next frame digit0 window shows seg_d = 8'hCF.
REQ-036 Write all 8 digits 0..7, no commit -> display stays dark for 3 frames; then commit -> digit i shows table value i from the following frame.
REQ-037 commit asserted 3 times within one frame plus wr_en in the boundary cycle -> exactly one commit_ack; the boundary-cycle write appears only after a second commit.
REQ-038 rst_n pulsed low mid-ON of digit 5 with commit pending -> outputs FF/00 immediately, restart at FE, no commit_ack, display dark.
